// File: rtl/countdown_seq_ctrl.sv
// countdown_seq_ctrl: turns a 0..99 sub-second counter into a seconds countdown timer.
//
// Ports:
//   clk, rst       rising-edge clock; synchronous active-high reset
//   start          arms the timer with load_sec (legal range 1..MAX_SEC)
//   pause_tog      toggles between RUN and PAUSE
//   abort          returns to IDLE from any state and clears secs
//   load_sec       initial seconds, sampled only on an accepted start
//   tick           base-rate tick, forwarded to the counter only in RUN
//   sub_timeout    wrap pulse from the sub-second counter
//   sub_incre      increment to the sub-second counter
//   sub_rst_n      active-low clear to the sub-second counter (released in RUN/PAUSE)
//   secs           remaining seconds
//   running/paused state decodes
//   expired        one-cycle pulse when the countdown reaches 0
//   load_err       one-cycle pulse on a rejected start
module countdown_seq_ctrl #(
  parameter int unsigned SEC_W   = 7,
  parameter int unsigned MAX_SEC = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause_tog,
  input  logic             abort,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             tick,
  input  logic             sub_timeout,
  output logic             sub_incre,
  output logic             sub_rst_n,
  output logic [SEC_W-1:0] secs,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             load_err
);

  localparam logic [SEC_W-1:0] MaxSec = SEC_W'(MAX_SEC);
  localparam logic [SEC_W-1:0] OneSec = SEC_W'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic             expired_q, expired_d;
  logic             load_err_q, load_err_d;
  logic             load_ok;

  always_comb begin
    state_d    = state_q;
    secs_d     = secs_q;
    expired_d  = 1'b0;
    load_err_d = 1'b0;
    load_ok    = (load_sec != '0) && (load_sec <= MaxSec);

    if (abort) begin
      // Abort beats everything, including a coincident expiry.
      state_d = StIdle;
      secs_d  = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            if (load_ok) begin
              secs_d  = load_sec;
              state_d = StArm;
            end else begin
              load_err_d = 1'b1;
            end
          end
        end
        StArm: state_d = StRun;
        StRun, StPause: begin
          // A timeout still counts in PAUSE: it comes from a tick in the last RUN cycle.
          if (sub_timeout) begin
            if (secs_q == OneSec) begin
              secs_d    = '0;
              state_d   = StDone;
              expired_d = 1'b1;
            end else if (secs_q != '0) begin
              secs_d = secs_q - OneSec;
            end
          end
          if (pause_tog && !expired_d) begin
            state_d = (state_q == StRun) ? StPause : StRun;
          end
        end
        default: begin
          state_d = StIdle;
          secs_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      secs_q     <= '0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      secs_q     <= secs_d;
      expired_q  <= expired_d;
      load_err_q <= load_err_d;
    end
  end

  // Only sub_incre sees an input directly; the rest decode the state register.
  assign sub_incre = tick && (state_q == StRun);
  assign sub_rst_n = (state_q == StRun) || (state_q == StPause);
  assign running   = (state_q == StRun);
  assign paused    = (state_q == StPause);
  assign secs      = secs_q;
  assign expired   = expired_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
module tb_countdown_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, pause_tog, abort, tick;
  logic [6:0] load_sec;
  logic       sub_timeout, sub_incre, sub_rst_n, running, paused, expired, load_err;
  logic [6:0] secs;

  // Sub-second counter model; the bench can bypass it and drive sub_timeout directly.
  logic       use_model, dir_to, mdl_to;
  logic [6:0] mdl_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  countdown_seq_ctrl #(.SEC_W(7), .MAX_SEC(99)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause_tog   (pause_tog),
    .abort       (abort),
    .load_sec    (load_sec),
    .tick        (tick),
    .sub_timeout (sub_timeout),
    .sub_incre   (sub_incre),
    .sub_rst_n   (sub_rst_n),
    .secs        (secs),
    .running     (running),
    .paused      (paused),
    .expired     (expired),
    .load_err    (load_err)
  );

  always @(posedge clk) begin
    if (!sub_rst_n) begin
      mdl_cnt <= 7'd0;
      mdl_to  <= 1'b0;
    end else if (sub_incre) begin
      if (mdl_cnt == 7'd99) begin
        mdl_cnt <= 7'd0;
        mdl_to  <= 1'b1;
      end else begin
        mdl_cnt <= mdl_cnt + 7'd1;
        mdl_to  <= 1'b0;
      end
    end else begin
      mdl_to <= 1'b0;
    end
  end

  assign sub_timeout = use_model ? mdl_to : dir_to;

  typedef struct {
    logic       st, pt, ab;
    logic [6:0] ld;
    logic       tk, to;
    int         secs;
    logic       run, pau, exp, lerr, srn, inc;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; pause_tog = 0; abort = 0; load_sec = 0; tick = 0; dir_to = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_secs"}, secs, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_paused"}, paused, 0);
    chk({tag, "_expired"}, expired, 0);
    chk({tag, "_load_err"}, load_err, 0);
    chk({tag, "_sub_rst_n"}, sub_rst_n, 0);
    chk({tag, "_sub_incre"}, sub_incre, 0);
  endtask

  initial begin
    int last, idx, t_last, n_exp, bad, c_hold, n;
    int vals[3];
    int gaps[3];
    bit found;

    //            st pt ab ld   tk to | secs run pau exp lerr srn inc
    vecs[0]  = '{0, 0, 0, 7'd0,   1, 0,  0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 7'd0,   0, 0,  0,  0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 7'd100, 0, 0,  0,  0, 0, 0, 1, 0, 0};
    vecs[3]  = '{1, 0, 0, 7'd2,   1, 0,  2,  0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 7'd0,   1, 0,  2,  1, 0, 0, 0, 1, 1};
    vecs[5]  = '{0, 0, 0, 7'd0,   0, 1,  1,  1, 0, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 0, 7'd0,   0, 0,  1,  0, 1, 0, 0, 1, 0};
    vecs[7]  = '{0, 0, 0, 7'd0,   1, 0,  1,  0, 1, 0, 0, 1, 0};
    vecs[8]  = '{1, 0, 0, 7'd5,   0, 0,  1,  0, 1, 0, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 7'd0,   1, 0,  1,  1, 0, 0, 0, 1, 1};
    vecs[10] = '{0, 1, 0, 7'd0,   0, 1,  0,  0, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 7'd0,   1, 0,  0,  0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 7'd0,   0, 1,  0,  0, 0, 0, 0, 0, 0};
    vecs[13] = '{1, 0, 0, 7'd0,   0, 0,  0,  0, 0, 0, 1, 0, 0};
    vecs[14] = '{1, 0, 0, 7'd3,   0, 0,  3,  0, 0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 1, 7'd0,   0, 0,  0,  0, 0, 0, 0, 0, 0};
    vecs[16] = '{1, 0, 0, 7'd2,   0, 0,  2,  0, 0, 0, 0, 0, 0};
    vecs[17] = '{0, 0, 0, 7'd0,   0, 1,  2,  1, 0, 0, 0, 1, 0};
    vecs[18] = '{0, 1, 0, 7'd0,   0, 1,  1,  0, 1, 0, 0, 1, 0};
    vecs[19] = '{0, 0, 1, 7'd0,   0, 1,  0,  0, 0, 0, 0, 0, 0};
    vecs[20] = '{0, 0, 0, 7'd0,   0, 0,  0,  0, 0, 0, 0, 0, 0};
    vecs[21] = '{1, 0, 1, 7'd4,   0, 0,  0,  0, 0, 0, 0, 0, 0};
    vecs[22] = '{0, 0, 0, 7'd0,   0, 1,  0,  0, 0, 0, 0, 0, 0};
    vecs[23] = '{1, 0, 0, 7'd99,  0, 0, 99,  0, 0, 0, 0, 0, 0};
    vecs[24] = '{0, 0, 1, 7'd0,   0, 0,  0,  0, 0, 0, 0, 0, 0};

    use_model = 0;
    clear_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    chk_idle("reset");

    // Directed table with sub_timeout driven straight from the vector.
    for (int i = 0; i < 25; i++) begin
      start = vecs[i].st; pause_tog = vecs[i].pt; abort = vecs[i].ab;
      load_sec = vecs[i].ld; tick = vecs[i].tk; dir_to = vecs[i].to;
      step();
      chk($sformatf("v%0d_secs", i), secs, vecs[i].secs);
      chk($sformatf("v%0d_running", i), running, vecs[i].run);
      chk($sformatf("v%0d_paused", i), paused, vecs[i].pau);
      chk($sformatf("v%0d_expired", i), expired, vecs[i].exp);
      chk($sformatf("v%0d_load_err", i), load_err, vecs[i].lerr);
      chk($sformatf("v%0d_sub_rst_n", i), sub_rst_n, vecs[i].srn);
      chk($sformatf("v%0d_sub_incre", i), sub_incre, vecs[i].inc);
    end
    clear_inputs();

    // Full 3-second countdown with the counter model and a tick every cycle.
    use_model = 1;
    do_reset();
    tick = 1; load_sec = 7'd3; start = 1;
    step();
    start = 0;
    chk("A_arm_sub_rst_n", sub_rst_n, 0);
    chk("A_arm_running", running, 0);
    chk("A_arm_secs", secs, 3);
    step();
    chk("A_run_running", running, 1);
    last = 3; idx = 0; t_last = 0; n_exp = 0;
    for (int c = 1; c <= 1000; c++) begin
      step();
      if (expired) n_exp++;
      if (secs != last) begin
        if (idx < 3) begin
          vals[idx] = secs;
          gaps[idx] = c - t_last;
        end
        idx++;
        t_last = c;
        last = secs;
      end
      if (!running && !paused) break;
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (expired) n_exp++;
    end
    chk("A_num_decrements", idx, 3);
    chk("A_val0", vals[0], 2);
    chk("A_val1", vals[1], 1);
    chk("A_val2", vals[2], 0);
    chk("A_gap0", gaps[0], 101);
    chk("A_gap1", gaps[1], 100);
    chk("A_gap2", gaps[2], 100);
    chk("A_expired_count", n_exp, 1);
    chk("A_done_running", running, 0);
    chk("A_done_paused", paused, 0);
    chk("A_done_sub_rst_n", sub_rst_n, 0);

    // Pause mid-second at secs=2, hold 500 ticks, resume without clearing the counter.
    do_reset();
    tick = 1; load_sec = 7'd3; start = 1;
    step();
    start = 0;
    found = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (secs == 7'd2) begin found = 1; break; end
    end
    chk("B_reached_2", found, 1);
    repeat (30) step();
    pause_tog = 1;
    step();
    pause_tog = 0;
    chk("B_paused", paused, 1);
    c_hold = mdl_cnt;
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      step();
      if (sub_incre || secs != 7'd2 || !sub_rst_n) bad++;
    end
    chk("B_hold_bad_cycles", bad, 0);
    chk("B_hold_count", mdl_cnt, c_hold);
    pause_tog = 1;
    step();
    pause_tog = 0;
    chk("B_resumed", running, 1);
    n = 0;
    found = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      n++;
      if (secs == 7'd1) begin found = 1; break; end
    end
    chk("B_reached_1", found, 1);
    chk("B_residual_cycles", n, 101 - c_hold);

    // Last-tick and pause in the same cycle with secs=1: timeout lands in PAUSE.
    do_reset();
    tick = 1; load_sec = 7'd1; start = 1;
    step();
    start = 0;
    step();
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (mdl_cnt == 7'd99 && running) begin found = 1; break; end
      step();
    end
    chk("C_found_last_tick", found, 1);
    pause_tog = 1;
    step();
    pause_tog = 0;
    chk("C_paused", paused, 1);
    chk("C_secs_before", secs, 1);
    chk("C_timeout_in_pause", sub_timeout, 1);
    step();
    chk("C_secs_after", secs, 0);
    chk("C_expired", expired, 1);
    chk("C_done_paused", paused, 0);
    chk("C_done_running", running, 0);
    chk("C_done_sub_rst_n", sub_rst_n, 0);
    step();
    chk("C_expired_one_cycle", expired, 0);
    tick = 0;

    // Reset in RUN at secs=5 overrides everything, then a fresh start arms normally.
    use_model = 0;
    do_reset();
    load_sec = 7'd5; start = 1;
    step();
    start = 0;
    step();
    chk("E_run_secs", secs, 5);
    chk("E_running", running, 1);
    rst = 1; start = 1; pause_tog = 1; dir_to = 1; tick = 1; load_sec = 7'd7;
    step();
    rst = 0; pause_tog = 0; dir_to = 0; start = 0; tick = 0;
    chk_idle("E_after_rst");
    load_sec = 7'd9; start = 1;
    step();
    start = 0;
    chk("E_arm_secs", secs, 9);
    chk("E_arm_sub_rst_n", sub_rst_n, 0);
    step();
    chk("E_run_running", running, 1);
    chk("E_run_secs9", secs, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_seq_ctrl.md
Name: countdown_seq_ctrl

Overview:
- Sequences the 0..99 sub-second counter into a seconds countdown timer.
- Gates the counter's increment input with the base tick and holds the counter cleared whenever the timer is not active.
- Consumes the counter's wrap (timeout) pulse to decrement a seconds register.
- Provides start/pause/abort control and a one-cycle expiry pulse to downstream display/game logic.

Parameters:
- SEC_W, 7, width of the seconds register and load value.
- MAX_SEC, 99, largest legal load value; loads of 0 or greater than MAX_SEC are rejected.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; arms the timer with load_sec.
- pause_tog  in  1  one-cycle pulse; toggles RUN/PAUSE.
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- load_sec  in  SEC_W  initial seconds, sampled only on an accepted start.
- tick  in  1  base-rate tick (nominally 100 Hz), one-cycle pulse.
- sub_timeout  in  1  wrap pulse from the sub-second counter (one cycle after its 100th increment).
- sub_incre  out  1  increment to the sub-second counter.
- sub_rst_n  out  1  active-low clear to the sub-second counter.
- secs  out  SEC_W  remaining seconds.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- expired  out  1  one-cycle pulse on countdown reaching 0.
- load_err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- States: IDLE, ARM, RUN, PAUSE, DONE; state register is binary-encoded.
- Reset (rst=1 at a clock edge), next cycle:
  - state=IDLE, secs=0.
  - expired=0, load_err=0.
  - running=0, paused=0.
  - sub_rst_n=0, sub_incre=0.
- Combinational outputs (decoded from the state register only; no input-to-output paths except sub_incre):
  - sub_incre = tick AND (state==RUN).
  - sub_rst_n = 1 only in RUN and PAUSE; 0 in IDLE, ARM and DONE.
  - running = (state==RUN); paused = (state==PAUSE).
- Registered pulses: expired and load_err are high for exactly one cycle, in the cycle after the triggering edge.
- Priority within any state: rst > abort > sub_timeout > pause_tog > start.
- IDLE:
  - start with 1 <= load_sec <= MAX_SEC: secs <= load_sec, go to ARM.
  - start with an illegal load_sec: load_err pulse, stay in IDLE, secs unchanged.
- ARM: one cycle with sub_rst_n=0 so the counter starts at 0; tick ignored; go to RUN unconditionally, unless abort (go to IDLE).
- RUN:
  - sub_timeout: secs <= secs-1. If secs was 1, go to DONE, secs becomes 0, and pulse expired.
  - pause_tog (without expiry in the same cycle): go to PAUSE. If sub_timeout coincides, the decrement is still applied.
  - start: ignored.
- PAUSE:
  - sub_incre is held 0.
  - A sub_timeout arriving here (from a tick in the last RUN cycle) is still honoured: decrement applies, with expiry to DONE if secs was 1.
  - pause_tog: go to RUN. start: ignored.
- DONE:
  - secs holds 0 and the counter is held cleared.
  - start: same acceptance rules as in IDLE (legal load goes to ARM, illegal load pulses load_err and stays in DONE).
- abort in ARM/RUN/PAUSE/DONE: go to IDLE and clear secs to 0. No expired pulse, even if sub_timeout coincides.
- Arithmetic:
  - secs never decrements below 0.
  - A sub_timeout in IDLE, ARM or DONE is ignored.
  - No wrap-around of secs.
- Reset asserted mid-countdown overrides all inputs in that cycle.

Test Plan:
- Reset, then load_sec=3 with start, 100 ticks per second and counter model attached:
  - ARM lasts 1 cycle with sub_rst_n=0.
  - secs steps 3→2→1→0 on each sub_timeout.
  - expired is high exactly 1 cycle, at the third timeout; state DONE with running=0.
- start with load_sec=0, then again with load_sec=100 (MAX_SEC=99):
  - load_err pulses once per attempt.
  - State stays IDLE, secs=0, sub_rst_n=0 throughout.
- Pause at secs=2 mid-second:
  - sub_incre stays 0 for 500 ticks and secs stays 2.
  - pause_tog resumes; remaining sub-count continues (counter not cleared) and timeout arrives after the residual ticks.
- Tick in the last RUN cycle, pause_tog in the same cycle, secs=1:
  - Counter timeout lands in PAUSE.
  - secs goes 0, expired pulses, state goes DONE.
- abort and sub_timeout in the same cycle with secs=1 → state IDLE, secs=0, expired never asserts.
- rst=1 while in RUN with secs=5:
  - Next cycle is IDLE with secs=0 and all outputs at reset values.
  - A following start with load_sec=9 arms normally.
